// File: rtl/instr_cache_arbiter_pkg.sv
// Shared types and defaults for the tile instruction-cache arbiter.
// Consumers import with: import instr_cache_arbiter_pkg::*;
package instr_cache_arbiter_pkg;

  localparam int unsigned ICACHE_ARB_NUM_REQ   = 2;
  localparam int unsigned ICACHE_ARB_MAX_OUTST = 4;

  typedef logic [$clog2(ICACHE_ARB_NUM_REQ)-1:0] icache_arb_id_t;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/instr_cache_arbiter_if.sv
// Requester-side and I$-side bus of the instruction-cache arbiter.
// slave = arbiter view, master = surrounding environment (requesters + I$).
interface instr_cache_arbiter_if #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned AddrW  = 32,
  parameter int unsigned DataW  = 32
);
  logic [NumReq-1:0]       req_i;
  logic [NumReq*AddrW-1:0] addr_i;
  logic [NumReq-1:0]       gnt_o;
  logic [NumReq-1:0]       rvalid_o;
  logic [DataW-1:0]        rdata_o;
  logic                    cache_req_o;
  logic [AddrW-1:0]        cache_addr_o;
  logic                    cache_gnt_i;
  logic                    cache_rvalid_i;
  logic [DataW-1:0]        cache_rdata_i;
  logic                    err_o;

  modport slave (
    input  req_i, addr_i, cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    output gnt_o, rvalid_o, rdata_o, cache_req_o, cache_addr_o, err_o
  );

  modport master (
    output req_i, addr_i, cache_gnt_i, cache_rvalid_i, cache_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, cache_req_o, cache_addr_o, err_o
  );
endinterface

// File: rtl/instr_cache_arbiter_id_fifo.sv
// Synchronous FIFO holding the requester id of each outstanding I$ transaction.
// Full is taken from the registered count, so a same-cycle pop does not free a slot.
module instr_cache_arbiter_id_fifo #(
  parameter int unsigned Depth  = 4,
  parameter type         WidthT = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  logic  pop_i,
  input  WidthT data_i,
  output logic  full_o,
  output logic  empty_o,
  output WidthT head_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  WidthT            r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/instr_cache_arbiter.sv
// Round-robin arbiter sharing one I$ port among NumReq fetch requesters, in-order responses.
// Optional per-requester perf counters enabled by defining MAGIA_ICACHE_ARB_PERF_EN.
module instr_cache_arbiter
  import instr_cache_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = ICACHE_ARB_NUM_REQ,
  parameter int unsigned AddrW    = 32,
  parameter int unsigned DataW    = 32,
  parameter int unsigned MaxOutst = ICACHE_ARB_MAX_OUTST
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  instr_cache_arbiter_if.slave  bus
`ifdef MAGIA_ICACHE_ARB_PERF_EN
  ,
  output logic [NumReq*64-1:0]  perf_cnt_o
`endif
);
  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdW-1:0] id_t;

  arb_state_e r_state, w_state_d;
  id_t        r_rr_ptr, w_rr_ptr_d;
  id_t        r_lock_id, w_lock_id_d;
  id_t        w_winner, w_sel, w_head;
  logic       r_err;
  logic       w_full, w_empty, w_creq, w_hs, w_pop;

  always_comb begin : rr_search
    logic        found;
    int unsigned idx;
    found    = 1'b0;
    idx      = 0;
    w_winner = r_rr_ptr;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(r_rr_ptr) + k) % NumReq;
      if (!found && bus.req_i[idx]) begin
        w_winner = id_t'(idx);
        found    = 1'b1;
      end
    end
  end

  assign w_sel  = (r_state == StLocked) ? r_lock_id : w_winner;
  assign w_creq = (|bus.req_i) & ~w_full;
  assign w_hs   = w_creq & bus.cache_gnt_i;
  assign w_pop  = bus.cache_rvalid_i & ~w_empty;

  always_comb begin
    w_state_d   = r_state;
    w_lock_id_d = r_lock_id;
    w_rr_ptr_d  = r_rr_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_creq && !bus.cache_gnt_i) begin
          w_state_d   = StLocked;
          w_lock_id_d = w_winner;
        end
      end
      StLocked: begin
        if (w_hs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (w_hs) w_rr_ptr_d = id_t'((32'(w_sel) + 32'd1) % NumReq);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_lock_id <= w_lock_id_d;
      r_rr_ptr  <= w_rr_ptr_d;
      if (bus.cache_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

  instr_cache_arbiter_id_fifo #(
    .Depth  (MaxOutst),
    .WidthT (id_t)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_hs),
    .pop_i   (w_pop),
    .data_i  (w_sel),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // Outputs are forced low while reset is asserted, independent of the inputs.
  always_comb begin
    bus.gnt_o        = '0;
    bus.rvalid_o     = '0;
    bus.rdata_o      = '0;
    bus.cache_req_o  = 1'b0;
    bus.cache_addr_o = '0;
    bus.err_o        = 1'b0;
    if (rst_ni) begin
      bus.cache_req_o  = w_creq;
      bus.cache_addr_o = bus.addr_i[32'(w_sel)*AddrW +: AddrW];
      bus.gnt_o[w_sel] = w_hs;
      bus.err_o        = r_err;
      if (w_pop) begin
        bus.rvalid_o[w_head] = 1'b1;
        bus.rdata_o          = bus.cache_rdata_i;
      end
    end
  end

`ifdef MAGIA_ICACHE_ARB_PERF_EN
  logic [31:0] r_grant_cnt [NumReq];
  logic [31:0] r_stall_cnt [NumReq];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        r_grant_cnt[i] <= '0;
        r_stall_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (bus.gnt_o[i]) r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
        if (bus.req_i[i] && !bus.gnt_o[i]) r_stall_cnt[i] <= sat_inc(r_stall_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_perf
    assign perf_cnt_o[g*64 +: 64] = {r_stall_cnt[g], r_grant_cnt[g]};
  end
`endif

endmodule

// File: tb/tb_instr_cache_arbiter.sv
// Directed bench for instr_cache_arbiter: reference model plus a scoreboard of outstanding ids.
module tb_instr_cache_arbiter;
  localparam int unsigned NumReq   = 2;
  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 32;
  localparam int unsigned MaxOutst = 4;
  localparam logic [31:0] Addr0    = 32'h0000_1000;
  localparam logic [31:0] Addr1    = 32'h0000_2040;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_cache_arbiter_if #(.NumReq(NumReq), .AddrW(AddrW), .DataW(DataW)) bus ();

`ifdef MAGIA_ICACHE_ARB_PERF_EN
  logic [NumReq*64-1:0] perf_cnt;
`endif

  instr_cache_arbiter #(
    .NumReq   (NumReq),
    .AddrW    (AddrW),
    .DataW    (DataW),
    .MaxOutst (MaxOutst)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef MAGIA_ICACHE_ARB_PERF_EN
    ,
    .perf_cnt_o (perf_cnt)
`endif
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned m_rr     = 0;
  int unsigned m_cnt    = 0;
  bit          m_locked = 1'b0;
  int unsigned m_lock_id = 0;
  bit          m_err    = 1'b0;
  int unsigned sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [1:0] req, input int unsigned rr);
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (req[(rr + k) % NumReq]) return (rr + k) % NumReq;
    end
    return rr;
  endfunction

  // One cycle: drive inputs after negedge, check combinational outputs, advance the model.
  task automatic step(input logic [1:0] req, input logic gnt, input logic rv,
                      input logic [31:0] rd);
    int unsigned sel;
    int unsigned id;
    logic        full;
    logic        creq;
    logic        pop;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    @(negedge clk);
    bus.req_i          = req;
    bus.cache_gnt_i    = gnt;
    bus.cache_rvalid_i = rv;
    bus.cache_rdata_i  = rd;
    #1;
    check("err", bus.err_o, m_err);
    full = (m_cnt == MaxOutst);
    sel  = m_locked ? m_lock_id : rr_pick(req, m_rr);
    creq = (req != 2'b00) && !full;
    check("cache_req", bus.cache_req_o, creq);
    if (creq) check("cache_addr", bus.cache_addr_o, (sel == 0) ? Addr0 : Addr1);
    exp_gnt = (creq && gnt) ? 2'(1 << sel) : 2'b00;
    check("gnt", bus.gnt_o, exp_gnt);
    exp_rv = 2'b00;
    pop    = 1'b0;
    if (rv) begin
      if (sb.size() > 0) begin
        id     = sb.pop_front();
        exp_rv = 2'(1 << id);
        pop    = 1'b1;
        check("rdata", bus.rdata_o, rd);
      end else begin
        m_err = 1'b1;
      end
    end
    check("rvalid", bus.rvalid_o, exp_rv);
    if (creq && gnt) begin
      sb.push_back(sel);
      m_rr     = (sel + 1) % NumReq;
      m_locked = 1'b0;
      m_cnt++;
    end else if (creq) begin
      m_locked  = 1'b1;
      m_lock_id = sel;
    end
    if (pop) m_cnt--;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt_o, 2'b00);
    check({tag, "_rvalid"}, bus.rvalid_o, 2'b00);
    check({tag, "_rdata"}, bus.rdata_o, 32'h0);
    check({tag, "_cache_req"}, bus.cache_req_o, 1'b0);
    check({tag, "_cache_addr"}, bus.cache_addr_o, 32'h0);
    check({tag, "_err"}, bus.err_o, 1'b0);
  endtask

  initial begin
    bus.req_i          = 2'b00;
    bus.addr_i         = {Addr1, Addr0};
    bus.cache_gnt_i    = 1'b0;
    bus.cache_rvalid_i = 1'b0;
    bus.cache_rdata_i  = 32'h0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester, response two cycles after the grant.
    step(2'b01, 1'b1, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Requester 1 alone, brings the round-robin pointer back to 0.
    step(2'b10, 1'b1, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b1, 32'h1111_0001);

    // Contention: four back-to-back handshakes alternate 0,1,0,1 and fill the FIFO.
    for (int i = 0; i < 4; i++) step(2'b11, 1'b1, 1'b0, 32'h0);

    // Full: no request; a pop does not reopen the port until the following cycle.
    step(2'b11, 1'b1, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b1, 32'h2222_0000);
    step(2'b11, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1, 32'h3333_0000 + 32'(i));

    // Lock on requester 0 while the pointer would otherwise favour requester 1.
    step(2'b01, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b1, 32'h4444_0000);

    // Routing 1,0,1 then an extra response on an empty FIFO raises err.
    step(2'b10, 1'b1, 1'b0, 32'h0);
    step(2'b01, 1'b1, 1'b0, 32'h0);
    step(2'b10, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1, 32'h5555_0000 + 32'(i));
    step(2'b00, 1'b0, 1'b0, 32'h0);

    // Reset with two outstanding and requests still asserted.
    step(2'b11, 1'b1, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    m_cnt    = 0;
    m_rr     = 0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    @(negedge clk);
    bus.req_i          = 2'b00;
    bus.cache_gnt_i    = 1'b0;
    bus.cache_rvalid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 1'b0, 1'b1, 32'h6666_0000);
    step(2'b11, 1'b1, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b1, 32'h7777_0000);
    step(2'b00, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
